// File: rtl/game_pkg.sv
// Shared types for the game-session controller: FSM states, display codes,
// BCD digit type and BCD magnitude compare.
package game_pkg;

  typedef enum logic [2:0] {
    S_LOGOUT   = 3'd0,
    S_INIT     = 3'd1,
    S_SETUP    = 3'd2,
    S_GAME     = 3'd3,
    S_GAMEOVER = 3'd4,
    S_TOPSCORE = 3'd5
  } state_t;

  localparam logic [2:0] CS_INIT     = 3'd0;
  localparam logic [2:0] CS_SETUP    = 3'd1;
  localparam logic [2:0] CS_GAME     = 3'd2;
  localparam logic [2:0] CS_GAMEOVER = 3'd3;
  localparam logic [2:0] CS_TOPSCORE = 3'd4;

  typedef logic [3:0] bcd_digit_t;

  // Packed BCD orders the same as plain binary, so a zero-extended compare suffices.
  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    return a > b;
  endfunction

  function automatic logic [2:0] cs_of(input state_t s);
    case (s)
      S_SETUP:    return CS_SETUP;
      S_GAME:     return CS_GAME;
      S_GAMEOVER: return CS_GAMEOVER;
      S_TOPSCORE: return CS_TOPSCORE;
      default:    return CS_INIT;
    endcase
  endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Player-input / display-side bundle of the game-session controller.
interface game_session_ctrl_if #(
  parameter int NUM_MODES    = 3,
  parameter int MODE_W       = 2,
  parameter int SCORE_DIGITS = 2,
  parameter int PID_W        = 3
) ();
  logic                      logOn;
  logic                      pwdPls;
  logic                      startPls;
  logic                      loadPls;
  logic                      isCorrect;
  logic                      timeOut;
  logic [PID_W-1:0]          pIDin;
  logic                      isGuestIn;
  logic [2:0]                controlSig;
  logic                      logOut;
  logic                      timerEn;
  logic                      timerReconfig;
  logic [MODE_W-1:0]         modeOut;
  logic [4*SCORE_DIGITS-1:0] scoreBcd;
  logic [4*SCORE_DIGITS-1:0] topScoreBcd;
  logic [PID_W-1:0]          topPID;
  logic [PID_W-1:0]          pIDout;
  logic                      isGuestOut;
  logic                      newRecord;

  modport master (
    output logOn, pwdPls, startPls, loadPls, isCorrect, timeOut, pIDin, isGuestIn,
    input  controlSig, logOut, timerEn, timerReconfig, modeOut, scoreBcd,
           topScoreBcd, topPID, pIDout, isGuestOut, newRecord
  );

  modport slave (
    input  logOn, pwdPls, startPls, loadPls, isCorrect, timeOut, pIDin, isGuestIn,
    output controlSig, logOut, timerEn, timerReconfig, modeOut, scoreBcd,
           topScoreBcd, topPID, pIDout, isGuestOut, newRecord
  );
endinterface

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; holds at all-9s.
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  bcd_digit_t [DIGITS-1:0] cnt_q, cnt_d;
  logic all9, carry;

  always_comb begin
    cnt_d = cnt_q;
    all9  = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (cnt_q[i] != 4'd9) all9 = 1'b0;
    carry = inc_i && !all9;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bcd_o = cnt_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Game-session FSM: login, mode select, timed BCD-scored round, game over and
// per-mode top-score table browsing. Display/timer outputs are registered.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int NUM_MODES    = 3,
  parameter int MODE_W       = 2,
  parameter int SCORE_DIGITS = 2,
  parameter int PID_W        = 3
) (
  input logic                clk,
  input logic                rst,
  game_session_ctrl_if.slave bus
);

  localparam int SW = 4 * SCORE_DIGITS;
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  state_t            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d, view_q, view_d, mode_out;
  logic [2:0]        cs_q;
  logic              log_q, ten_q, trc_q, rec_q, guest_q, entry_q;
  logic [PID_W-1:0]  pid_q;
  logic              score_clr, score_inc;
  logic [SW-1:0]     score;
  logic [SW-1:0]     cur_top, view_top;
  logic [PID_W-1:0]  view_pid;

  logic [NUM_MODES-1:0][SW-1:0]    top_q;
  logic [NUM_MODES-1:0][PID_W-1:0] tpid_q;

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk   (clk),
    .rst   (rst),
    .clr_i (score_clr),
    .inc_i (score_inc),
    .bcd_o (score)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    view_d    = view_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      S_LOGOUT: state_d = S_INIT;
      S_INIT: begin
        mode_d    = '0;
        score_clr = 1'b1;
        if (bus.logOn) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (bus.pwdPls) begin
          state_d = S_LOGOUT;
        end else if (bus.loadPls) begin
          if (mode_q == LAST_MODE) begin
            mode_d  = '0;
            view_d  = '0;
            state_d = S_TOPSCORE;
          end else begin
            mode_d = mode_q + 1'b1;
          end
        end else if (bus.startPls) begin
          score_clr = 1'b1;
          state_d   = S_GAME;
        end
      end
      S_GAME: begin
        // A correct answer landing with the exit pulse still scores.
        score_inc = bus.isCorrect;
        if (bus.pwdPls)       state_d = S_INIT;
        else if (bus.timeOut) state_d = S_GAMEOVER;
      end
      S_GAMEOVER: if (bus.startPls) state_d = S_INIT;
      S_TOPSCORE: begin
        if (bus.pwdPls)        state_d = S_LOGOUT;
        else if (bus.loadPls)  state_d = S_INIT;
        else if (bus.startPls) view_d  = (view_q == LAST_MODE) ? '0 : view_q + 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign mode_out = (state_q == S_TOPSCORE) ? view_q : mode_q;

  always_comb begin
    cur_top  = '0;
    view_top = '0;
    view_pid = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (mode_q == MODE_W'(i)) cur_top = top_q[i];
      if (mode_out == MODE_W'(i)) begin
        view_top = top_q[i];
        view_pid = tpid_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_LOGOUT;
      mode_q  <= '0;
      view_q  <= '0;
      cs_q    <= '0;
      log_q   <= 1'b0;
      ten_q   <= 1'b0;
      trc_q   <= 1'b0;
      rec_q   <= 1'b0;
      entry_q <= 1'b0;
      pid_q   <= '0;
      guest_q <= 1'b0;
      top_q   <= '0;
      tpid_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      view_q  <= view_d;
      cs_q    <= cs_of(state_d);
      log_q   <= (state_q == S_LOGOUT);
      ten_q   <= (state_d == S_GAME);
      trc_q   <= (state_d == S_INIT);
      entry_q <= (state_q == S_GAME) && (state_d == S_GAMEOVER);
      rec_q   <= 1'b0;
      // First GAMEOVER cycle: score is final, so latch the player and update the table.
      if (entry_q) begin
        pid_q   <= bus.pIDin;
        guest_q <= bus.isGuestIn;
        if (!bus.isGuestIn && bcd_gt(16'(score), 16'(cur_top))) begin
          rec_q <= 1'b1;
          for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_q == MODE_W'(i)) begin
              top_q[i]  <= score;
              tpid_q[i] <= bus.pIDin;
            end
          end
        end
      end
    end
  end

  assign bus.controlSig    = cs_q;
  assign bus.logOut        = log_q;
  assign bus.timerEn       = ten_q;
  assign bus.timerReconfig = trc_q;
  assign bus.modeOut       = mode_out;
  assign bus.scoreBcd      = score;
  assign bus.topScoreBcd   = view_top;
  assign bus.topPID        = view_pid;
  assign bus.pIDout        = pid_q;
  assign bus.isGuestOut    = guest_q;
  assign bus.newRecord     = rec_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: drives pulses on negedges, samples on negedges.
module tb_game_session_ctrl;
  localparam int NUM_MODES    = 3;
  localparam int MODE_W       = 2;
  localparam int SCORE_DIGITS = 2;
  localparam int PID_W        = 3;

  localparam int P_LOGON = 0, P_PWD = 1, P_START = 2, P_LOAD = 3, P_TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_session_ctrl_if #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .SCORE_DIGITS(SCORE_DIGITS), .PID_W(PID_W)
  ) bus ();

  game_session_ctrl #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .SCORE_DIGITS(SCORE_DIGITS), .PID_W(PID_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pls(input int sel);
    case (sel)
      P_LOGON: bus.logOn    = 1'b1;
      P_PWD:   bus.pwdPls   = 1'b1;
      P_START: bus.startPls = 1'b1;
      P_LOAD:  bus.loadPls  = 1'b1;
      default: bus.timeOut  = 1'b1;
    endcase
    tick(1);
    bus.logOn = 1'b0; bus.pwdPls = 1'b0; bus.startPls = 1'b0;
    bus.loadPls = 1'b0; bus.timeOut = 1'b0;
  endtask

  task automatic correct(input int n);
    bus.isCorrect = 1'b1;
    tick(n);
    bus.isCorrect = 1'b0;
  endtask

  // From INIT: log in, step to the mode, play n correct answers (no timeout yet).
  task automatic start_game(input int steps, input int pid, input logic guest, input int n);
    pls(P_LOGON);
    repeat (steps) pls(P_LOAD);
    bus.pIDin     = PID_W'(pid);
    bus.isGuestIn = guest;
    pls(P_START);
    if (n > 0) correct(n);
  endtask

  initial begin
    rst = 1'b0;
    bus.logOn = 1'b0; bus.pwdPls = 1'b0; bus.startPls = 1'b0; bus.loadPls = 1'b0;
    bus.isCorrect = 1'b0; bus.timeOut = 1'b0; bus.pIDin = '0; bus.isGuestIn = 1'b0;
    tick(2);
    chk("rst_cs",     32'(bus.controlSig), 0);
    chk("rst_logout", 32'(bus.logOut), 0);
    chk("rst_trc",    32'(bus.timerReconfig), 0);
    chk("rst_score",  32'(bus.scoreBcd), 0);

    rst = 1'b1;
    tick(1);
    chk("logout_pulse", 32'(bus.logOut), 1);
    chk("init_cs",      32'(bus.controlSig), 0);
    chk("init_trc",     32'(bus.timerReconfig), 1);
    tick(1);
    chk("logout_once",  32'(bus.logOut), 0);

    pls(P_LOGON);
    chk("setup_cs",  32'(bus.controlSig), 1);
    chk("setup_trc", 32'(bus.timerReconfig), 0);
    pls(P_LOAD);
    pls(P_LOAD);
    chk("mode_2", 32'(bus.modeOut), 2);
    pls(P_LOAD);
    chk("top_cs",   32'(bus.controlSig), 4);
    chk("top_view", 32'(bus.modeOut), 0);
    pls(P_START);
    chk("view_1", 32'(bus.modeOut), 1);
    pls(P_START);
    pls(P_START);
    chk("view_wrap", 32'(bus.modeOut), 0);
    pls(P_LOAD);
    chk("top_exit", 32'(bus.controlSig), 0);

    // Mode 0, pID 5, 12 correct answers -> new record
    start_game(0, 5, 1'b0, 0);
    chk("game_cs",  32'(bus.controlSig), 2);
    chk("game_ten", 32'(bus.timerEn), 1);
    correct(12);
    chk("score_12", 32'(bus.scoreBcd), 32'h12);
    pls(P_TO);
    chk("go_cs",    32'(bus.controlSig), 3);
    chk("go_ten",   32'(bus.timerEn), 0);
    chk("go_rec0",  32'(bus.newRecord), 0);
    tick(1);
    chk("rec_pulse", 32'(bus.newRecord), 1);
    chk("top_12",    32'(bus.topScoreBcd), 32'h12);
    chk("top_pid5",  32'(bus.topPID), 5);
    chk("pidout5",   32'(bus.pIDout), 5);
    tick(1);
    chk("rec_once",  32'(bus.newRecord), 0);
    chk("go_hold",   32'(bus.scoreBcd), 32'h12);
    pls(P_START);

    // Mode 1, pID 3, 105 answers saturate at 99
    start_game(1, 3, 1'b0, 105);
    chk("sat_99", 32'(bus.scoreBcd), 32'h99);
    pls(P_TO);
    tick(1);
    chk("sat_rec",  32'(bus.newRecord), 1);
    chk("sat_top",  32'(bus.topScoreBcd), 32'h99);
    chk("sat_pid",  32'(bus.topPID), 3);
    pls(P_START);

    // Mode 2, guest scoring 50 -> table untouched
    start_game(2, 4, 1'b1, 50);
    chk("guest_50", 32'(bus.scoreBcd), 32'h50);
    pls(P_TO);
    tick(1);
    chk("guest_norec", 32'(bus.newRecord), 0);
    chk("guest_top",   32'(bus.topScoreBcd), 0);
    chk("guest_flag",  32'(bus.isGuestOut), 1);
    pls(P_START);

    // Mode 0: isCorrect with timeOut at score 09 -> 10, below record
    start_game(0, 6, 1'b0, 9);
    chk("pre_09", 32'(bus.scoreBcd), 32'h09);
    bus.isCorrect = 1'b1;
    pls(P_TO);
    bus.isCorrect = 1'b0;
    chk("same_cs",  32'(bus.controlSig), 3);
    chk("same_10",  32'(bus.scoreBcd), 32'h10);
    tick(1);
    chk("same_norec", 32'(bus.newRecord), 0);
    chk("same_pid",   32'(bus.topPID), 5);
    chk("same_pidout", 32'(bus.pIDout), 6);
    pls(P_START);

    // Mode 0 tie at 12 keeps holder 5
    start_game(0, 7, 1'b0, 12);
    pls(P_TO);
    tick(1);
    chk("tie_norec", 32'(bus.newRecord), 0);
    chk("tie_pid",   32'(bus.topPID), 5);
    pls(P_START);

    // pwdPls during GAME -> INIT, no record
    start_game(0, 2, 1'b0, 20);
    pls(P_PWD);
    chk("abort_cs",  32'(bus.controlSig), 0);
    tick(1);
    chk("abort_rec", 32'(bus.newRecord), 0);
    chk("abort_top", 32'(bus.topScoreBcd), 32'h12);
    chk("abort_clr", 32'(bus.scoreBcd), 0);

    // SETUP pwdPls -> LOGOUT -> one logOut strobe
    pls(P_LOGON);
    pls(P_PWD);
    tick(1);
    chk("pwd_logout", 32'(bus.logOut), 1);

    // Reset mid-GAME
    start_game(0, 1, 1'b0, 5);
    rst = 1'b0;
    tick(1);
    chk("mid_ten",   32'(bus.timerEn), 0);
    chk("mid_score", 32'(bus.scoreBcd), 0);
    chk("mid_top",   32'(bus.topScoreBcd), 0);
    chk("mid_cs",    32'(bus.controlSig), 0);
    rst = 1'b1;
    tick(1);
    chk("mid_logout", 32'(bus.logOut), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
